// File: rtl/eth_frame_arbiter.sv
// Frame-level round-robin arbiter: shares one IP parser between NUM_PORTS MAC RX byte streams.
// A grant is held for a whole frame. Every forwarded frame ends with an eof beat, including
// frames cut short by a stall timeout or by exceeding MAX_FRAME_LEN.
module eth_frame_arbiter #(
    parameter int unsigned NUM_PORTS      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned MAX_FRAME_LEN  = 1522
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [8*NUM_PORTS-1:0]       src_data,
    input  logic [NUM_PORTS-1:0]         src_valid,
    input  logic [NUM_PORTS-1:0]         src_eof,
    input  logic [NUM_PORTS-1:0]         src_err,
    output logic [NUM_PORTS-1:0]         src_ready,
    output logic [7:0]                   out_data,
    output logic                         out_byte_valid,
    output logic                         out_eof,
    output logic                         out_err,
    output logic [$clog2(NUM_PORTS)-1:0] grant_id,
    output logic                         busy,
    output logic [15:0]                  stat_timeout_cnt,
    output logic [15:0]                  stat_oversize_cnt
);

    localparam int unsigned GW = $clog2(NUM_PORTS);
    localparam int unsigned IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BW = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FWD   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [GW-1:0] grant_d;
    logic [GW-1:0] rr_q, rr_d;
    logic [BW-1:0] byte_q, byte_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [7:0]    data_d;
    logic          bv_d, eof_d, err_d, busy_d;
    logic [15:0]   to_cnt_d, ov_cnt_d;

    logic          active;
    logic          sel_valid, sel_eof, sel_err;
    logic [7:0]    sel_data;
    logic          accept;
    logic [GW-1:0] next_ptr;
    logic [BW-1:0] byte_inc;
    logic [IW-1:0] idle_inc;
    logic          found;
    logic [GW-1:0] pick;

    assign active   = (state_q == ST_FWD) || (state_q == ST_DRAIN);
    assign sel_valid = src_valid[grant_id];
    assign sel_eof   = src_eof[grant_id];
    assign sel_err   = src_err[grant_id];
    assign sel_data  = src_data[{grant_id, 3'b000} +: 8];
    assign accept    = active && sel_valid;
    assign next_ptr  = (grant_id == GW'(NUM_PORTS - 1)) ? '0 : grant_id + GW'(1);
    assign byte_inc  = byte_q + BW'(1);
    assign idle_inc  = idle_q + IW'(1);

    // Ready is decoded from registered state only, never from src_valid.
    always_comb begin
        src_ready = '0;
        if (active) begin
            src_ready[grant_id] = 1'b1;
        end
    end

    // Round-robin search: first valid port at or above rr_q, wrapping.
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        pick  = rr_q;
        idx   = 0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            idx = (32'(rr_q) + k) % NUM_PORTS;
            if (!found && src_valid[GW'(idx)]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    // Next-state and registered-output values.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_id;
        rr_d     = rr_q;
        byte_d   = byte_q;
        idle_d   = idle_q;
        data_d   = out_data;
        bv_d     = 1'b0;
        eof_d    = 1'b0;
        err_d    = 1'b0;
        to_cnt_d = stat_timeout_cnt;
        ov_cnt_d = stat_oversize_cnt;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = ST_FWD;
                    byte_d  = '0;
                    idle_d  = '0;
                end
            end

            ST_FWD: begin
                if (accept) begin
                    idle_d = '0;
                    byte_d = byte_inc;
                    bv_d   = 1'b1;
                    data_d = sel_data;
                    if (sel_eof) begin
                        eof_d   = 1'b1;
                        err_d   = sel_err;
                        state_d = ST_IDLE;
                        rr_d    = next_ptr;
                    end else if (byte_inc == BW'(MAX_FRAME_LEN)) begin
                        // Frame too long: close it here as errored, discard the rest.
                        eof_d    = 1'b1;
                        err_d    = 1'b1;
                        ov_cnt_d = (stat_oversize_cnt == 16'hFFFF) ? stat_oversize_cnt
                                                                   : stat_oversize_cnt + 16'd1;
                        state_d  = ST_DRAIN;
                    end
                end else if (idle_inc == IW'(TIMEOUT_CYCLES)) begin
                    // Source stalled too long: emit a synthetic errored eof beat.
                    bv_d     = 1'b1;
                    data_d   = 8'h00;
                    eof_d    = 1'b1;
                    err_d    = 1'b1;
                    to_cnt_d = (stat_timeout_cnt == 16'hFFFF) ? stat_timeout_cnt
                                                              : stat_timeout_cnt + 16'd1;
                    state_d  = ST_DRAIN;
                    idle_d   = '0;
                end else begin
                    idle_d = idle_inc;
                end
            end

            ST_DRAIN: begin
                if (accept) begin
                    idle_d = '0;
                    if (sel_eof) begin
                        state_d = ST_IDLE;
                        rr_d    = next_ptr;
                    end
                end else if (idle_inc == IW'(TIMEOUT_CYCLES)) begin
                    state_d = ST_IDLE;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_inc;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= ST_IDLE;
            grant_id          <= '0;
            rr_q              <= '0;
            byte_q            <= '0;
            idle_q            <= '0;
            out_data          <= '0;
            out_byte_valid    <= 1'b0;
            out_eof           <= 1'b0;
            out_err           <= 1'b0;
            busy              <= 1'b0;
            stat_timeout_cnt  <= '0;
            stat_oversize_cnt <= '0;
        end else begin
            state_q           <= state_d;
            grant_id          <= grant_d;
            rr_q              <= rr_d;
            byte_q            <= byte_d;
            idle_q            <= idle_d;
            out_data          <= data_d;
            out_byte_valid    <= bv_d;
            out_eof           <= eof_d;
            out_err           <= err_d;
            busy              <= busy_d;
            stat_timeout_cnt  <= to_cnt_d;
            stat_oversize_cnt <= ov_cnt_d;
        end
    end

endmodule
